bnn_input_sender: RTL and testbench



---
 rtl/bnn_input_sender.sv | 120 ++++++++++++
 tb/tb_bnn_input_sender.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_input_sender.sv
// bnn_input_sender: packs a serial byte stream into 128-bit vectors held in a
// two-entry ping-pong buffer, and offers each full vector to the first BNN
// layer as the initiating side of the layer req/ack handshake.
module bnn_input_sender #(
  parameter int unsigned VEC_W  = 128,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              tx_req,
  output logic              tx_ack,
  output logic [VEC_W-1:0]  tx_data,
  output logic [15:0]       vec_cnt,
  output logic              busy
);

  localparam int unsigned NumBeats = VEC_W / BYTE_W;
  localparam int unsigned BeatW    = $clog2(NumBeats);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_REQ,
    ST_ACK,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic             wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [15:0]      vec_cnt_q, vec_cnt_d;

  logic             accept, fill_done, pop;
  logic [VEC_W-1:0] wr_mask, wr_data;

  assign in_ready  = (fcnt_q != 2'd2);
  assign accept    = in_valid & in_ready;
  assign fill_done = accept & (beat_q == LastBeat);
  assign pop       = (state_q == ST_DONE);

  // Beat k lands in byte lane k of the packing buffer.
  assign wr_mask = {{(VEC_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << (BYTE_W * beat_q);
  assign wr_data = {{(VEC_W-BYTE_W){1'b0}}, in_data} << (BYTE_W * beat_q);

  assign tx_data = rd_sel_q ? buf1_q : buf0_q;
  assign vec_cnt = vec_cnt_q;
  assign busy    = (fcnt_q != 2'd0) || (beat_q != '0);

  // Packing datapath and buffer bookkeeping next-state.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    beat_d    = beat_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    fcnt_d    = fcnt_q;
    vec_cnt_d = vec_cnt_q;
    if (accept) begin
      if (wr_sel_q) buf1_d = (buf1_q & ~wr_mask) | (wr_data & wr_mask);
      else          buf0_d = (buf0_q & ~wr_mask) | (wr_data & wr_mask);
      beat_d = fill_done ? '0 : beat_q + BeatW'(1);
    end
    if (fill_done) wr_sel_d = ~wr_sel_q;
    if (pop) begin
      rd_sel_d  = ~rd_sel_q;
      vec_cnt_d = vec_cnt_q + 16'd1;
    end
    // Fill and pop in the same cycle leave the count unchanged.
    unique case ({fill_done, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Delivery FSM next-state and ack output.
  always_comb begin
    state_d = state_q;
    tx_ack  = 1'b0;
    unique case (state_q)
      ST_IDLE:     if (fcnt_q != 2'd0) state_d = ST_WAIT_REQ;
      ST_WAIT_REQ: if (tx_req) state_d = ST_ACK;
      ST_ACK: begin
        tx_ack = 1'b1;
        if (!tx_req) state_d = ST_DONE;
      end
      ST_DONE:     state_d = (fcnt_d != 2'd0) ? ST_WAIT_REQ : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State register; reset discards partial and full buffers.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q   <= ST_IDLE;
      buf0_q    <= '0;
      buf1_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      fcnt_q    <= 2'd0;
      beat_q    <= '0;
      vec_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      fcnt_q    <= fcnt_d;
      beat_q    <= beat_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

endmodule

// File: tb/tb_bnn_input_sender.sv
// Bench for bnn_input_sender: expected vectors are queued at stimulus time and
// a monitor compares tx_data against the queue head on every ack rise.
module tb_bnn_input_sender;

  logic         clk = 1'b0;
  logic         xrst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         tx_req;
  logic         tx_ack;
  logic [127:0] tx_data;
  logic [15:0]  vec_cnt;
  logic         busy;

  logic layer_auto = 1'b0;
  logic req_auto   = 1'b0;
  logic req_man    = 1'b0;
  int   calc_cycles = 2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;
  int acc_cyc = 0;
  int rdy_low = 0;
  logic ack_prev = 1'b0;
  logic [127:0] exp_q[$];

  assign tx_req = layer_auto ? req_auto : req_man;

  bnn_input_sender #(.VEC_W(128), .BYTE_W(8)) dut (
    .clk      (clk),
    .xrst     (xrst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .tx_data  (tx_data),
    .vec_cnt  (vec_cnt),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: pop and compare on each ack rise.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (tx_ack && !ack_prev) begin
        ack_cnt++;
        ack_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got data %h want no ack", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e);
        end
      end
      if (!in_ready) rdy_low++;
      ack_prev = tx_ack;
    end
  end

  // Layer model: raise req, drop it once ack is seen, then compute.
  initial forever begin
    @(negedge clk);
    if (layer_auto) begin
      req_auto = 1'b1;
      while (layer_auto && !tx_ack) @(negedge clk);
      req_auto = 1'b0;
      repeat (calc_cycles) @(negedge clk);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 5000 cycles");
    end
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic send_vec(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) send_byte(base + 8'(k));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 3000) begin
      bad++;
      $display("FAIL %s: got pending=%0d busy=%0b want drained", name, exp_q.size(), busy);
    end
  endtask

  task automatic wait_ack(input string name);
    int g = 0;
    while (!tx_ack && g < 200) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 200) begin
      bad++;
      $display("FAIL %s: got tx_ack=0 want 1 within 200 cycles", name);
    end
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    layer_auto = 1'b0;
    req_man    = 1'b0;
    xrst       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int ack_base, err_ack, err_rdy, err_data;
    xrst     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_in_ready", in_ready, 1);
    check("rst_tx_ack", tx_ack, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    xrst = 1'b1;
    @(negedge clk);

    // Single vector, req already high.
    calc_cycles = 2;
    layer_auto  = 1'b1;
    exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    send_vec(8'h00, 16);
    wait_drain("single_drain");
    check("ack_latency", 128'(ack_cyc - acc_cyc), 128'd2);
    check("single_vec_cnt", vec_cnt, 1);

    // Back-to-back with slow layer.
    do_reset();
    rdy_low     = 0;
    calc_cycles = 140;
    layer_auto  = 1'b1;
    exp_q.push_back(128'h2F2E2D2C2B2A29282726252423222120);
    exp_q.push_back(128'h3F3E3D3C3B3A39383736353433323130);
    exp_q.push_back(128'h4F4E4D4C4B4A49484746454443424140);
    send_vec(8'h20, 48);
    wait_drain("b2b_drain");
    check("b2b_backpressure_seen", (rdy_low > 0), 1);
    check("b2b_vec_cnt", vec_cnt, 3);

    // Reset mid-stream: sender in ACK, fcnt=1, beat 7.
    layer_auto = 1'b0;
    req_man    = 1'b1;
    exp_q.push_back(128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0);
    send_vec(8'hB0, 16);
    wait_ack("midrst_ack");
    send_vec(8'hC0, 7);
    xrst = 1'b0;
    #1;
    check("midrst_tx_ack", tx_ack, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_vec_cnt", vec_cnt, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_busy", busy, 0);
    req_man = 1'b0;
    @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);

    // Counter wrap; also shows the discarded partial left no residue.
    force dut.vec_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.vec_cnt_q;
    @(negedge clk);
    check("wrap_preload", vec_cnt, 16'hFFFF);
    calc_cycles = 2;
    layer_auto  = 1'b1;
    exp_q.push_back(128'h9F9E9D9C9B9A99989796959493929190);
    send_vec(8'h90, 16);
    wait_drain("wrap_drain");
    check("wrap_vec_cnt", vec_cnt, 0);

    // Fill completion coincides with pop.
    do_reset();
    exp_q.push_back(128'h5F5E5D5C5B5A59585756555453525150);
    exp_q.push_back(128'h6F6E6D6C6B6A69686766656463626160);
    send_vec(8'h50, 16);
    send_vec(8'h60, 15);
    req_man = 1'b1;
    @(negedge clk);
    check("bnd_ack_a", tx_ack, 1);
    req_man = 1'b0;
    @(negedge clk);
    check("bnd_done_ack_low", tx_ack, 0);
    in_valid = 1'b1;
    in_data  = 8'h6F;
    @(negedge clk);
    in_valid = 1'b0;
    check("bnd_in_ready", in_ready, 1);
    check("bnd_busy", busy, 1);
    check("bnd_vec_cnt1", vec_cnt, 1);
    req_man = 1'b1;
    @(negedge clk);
    check("bnd_ack_b_one_cycle", tx_ack, 1);
    req_man = 1'b0;
    wait_drain("bnd_drain");
    check("bnd_vec_cnt2", vec_cnt, 2);

    // Req held low with both buffers full.
    do_reset();
    exp_q.push_back(128'h7F7E7D7C7B7A79787776757473727170);
    exp_q.push_back(128'h8F8E8D8C8B8A89888786858483828180);
    send_vec(8'h70, 32);
    @(negedge clk);
    err_ack  = 0;
    err_rdy  = 0;
    err_data = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ack) err_ack++;
      if (in_ready) err_rdy++;
      if (tx_data !== 128'h7F7E7D7C7B7A79787776757473727170) err_data++;
      @(negedge clk);
    end
    check("hold_ack_low_cycles", err_ack, 0);
    check("hold_in_ready_low_cycles", err_rdy, 0);
    check("hold_data_change_cycles", err_data, 0);
    ack_base = ack_cnt;
    req_man  = 1'b1;
    wait_ack("hold_ack");
    req_man = 1'b0;
    @(negedge clk);
    check("hold_done_data", tx_data, 128'h7F7E7D7C7B7A79787776757473727170);
    check("hold_done_ack", tx_ack, 0);
    check("hold_done_in_ready", in_ready, 0);
    @(negedge clk);
    check("hold_pop_in_ready", in_ready, 1);
    check("hold_single_ack", ack_cnt - ack_base, 1);
    calc_cycles = 2;
    layer_auto  = 1'b1;
    wait_drain("hold_drain");
    check("hold_vec_cnt", vec_cnt, 2);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
